// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage load-use hazard / stall controller.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CTRL_W     = 11;

    // Control bundle field positions, counted from the LSB; bit 10 is spare in the default bundle.
    localparam int JUMP_BIT      = 0;
    localparam int REG_WRITE_BIT = 1;
    localparam int ALU_SRC_BIT   = 2;
    localparam int MEM_WRITE_BIT = 3;
    localparam int MEM_2_REG_BIT = 4;
    localparam int MEM_READ_BIT  = 5;
    localparam int BRANCH_BIT    = 6;
    localparam int REG_DST_BIT   = 7;
    localparam int ALU_OP_LSB    = 8;
    localparam int ALU_OP_MSB    = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Cycles still owed after the detecting cycle, as loaded into the 4-bit remaining counter.
    function automatic logic [3:0] stall_reload(input int load_lat);
        return 4'(load_lat - 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Load-use RAW comparator: flags a source operand that matches a pending load destination.
module hazard_match #(
    parameter int REG_ADDR_W  = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  memread_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    output logic                  hit_o
);

    logic rs1_match;
    logic rs2_match;
    logic rd_is_zero;

    assign rs1_match  = use_rs1_i && (rs1_i == rd_i);
    assign rs2_match  = use_rs2_i && (rs2_i == rd_i);
    assign rd_is_zero = (rd_i == '0);

    // A load into x0 never produces a value anyone can depend on.
    assign hit_o = memread_i && (rs1_match || rs2_match) && !(ZERO_REG_EN && rd_is_zero);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: multi-cycle load-use stalls, branch flush priority, stall counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int CTRL_W      = DEF_CTRL_W,
    parameter int LOAD_LAT    = 1,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CTRL_W-1:0]     ctrl_in,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    output logic [CTRL_W-1:0]     ctrl_out,
    output logic                  prevent_update_pc,
    output logic                  prevent_update_reg_IF_ID,
    output logic                  flush_IF_ID,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [3:0] REM_RELOAD = stall_reload(LOAD_LAT);

    state_e           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic             stall;

    hazard_match #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match (
        .memread_i (ex_memread),
        .rd_i      (ex_rd),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .use_rs1_i (id_use_rs1),
        .use_rs2_i (id_use_rs2),
        .hit_o     (hit)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall       = 1'b0;
        flush_IF_ID = 1'b0;
        ctrl_out    = ctrl_in;

        unique case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    flush_IF_ID = 1'b1;
                    ctrl_out    = '0;
                end else if (hit) begin
                    stall    = 1'b1;
                    ctrl_out = '0;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        rem_d   = REM_RELOAD;
                    end
                end
            end
            STALL: begin
                // ID/EX already holds a bubble, so hit is meaningless until the stall ends.
                ctrl_out = '0;
                if (branch_taken) begin
                    flush_IF_ID = 1'b1;
                    state_d     = IDLE;
                    rem_d       = '0;
                end else begin
                    stall = 1'b1;
                    rem_d = rem_q - 4'd1;
                    if (rem_q <= 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    assign prevent_update_pc        = stall;
    assign prevent_update_reg_IF_ID = stall;

    // Saturating: once all-ones the count stays put.
    assign cnt_d       = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign stall_count = cnt_q;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: four parameter variants driven in lockstep, checked against a cycle model.
module tb_hazard_stall_ctrl;

    localparam int RW = 5;
    localparam int CW = 11;
    localparam int NI = 4;

    // Per-instance configuration: LOAD_LAT, counter ceiling, x0 exclusion.
    int lat  [NI] = '{1, 3, 1, 15};
    int cmax [NI] = '{65535, 65535, 15, 65535};
    bit zen  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] ctrl_in;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memread, branch_taken;

    logic [NI-1:0][CW-1:0] ctrl_o;
    logic [NI-1:0]         ppc, pif, fl;
    logic [15:0]           sc0, sc1, sc3;
    logic [3:0]            sc2;
    logic [NI-1:0][15:0]   scnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: stall cycles still owed after the current one, and expected counter.
    int m_rem [NI] = '{0, 0, 0, 0};
    int m_cnt [NI] = '{0, 0, 0, 0};

    assign scnt[0] = sc0;
    assign scnt[1] = sc1;
    assign scnt[2] = {12'd0, sc2};
    assign scnt[3] = sc3;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_LAT(1), .ZERO_REG_EN(1'b1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .ctrl_out(ctrl_o[0]), .prevent_update_pc(ppc[0]),
        .prevent_update_reg_IF_ID(pif[0]), .flush_IF_ID(fl[0]), .stall_count(sc0));

    hazard_stall_ctrl #(.LOAD_LAT(3), .ZERO_REG_EN(1'b1), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .ctrl_out(ctrl_o[1]), .prevent_update_pc(ppc[1]),
        .prevent_update_reg_IF_ID(pif[1]), .flush_IF_ID(fl[1]), .stall_count(sc1));

    hazard_stall_ctrl #(.LOAD_LAT(1), .ZERO_REG_EN(1'b0), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .ctrl_out(ctrl_o[2]), .prevent_update_pc(ppc[2]),
        .prevent_update_reg_IF_ID(pif[2]), .flush_IF_ID(fl[2]), .stall_count(sc2));

    hazard_stall_ctrl #(.LOAD_LAT(15), .ZERO_REG_EN(1'b1), .CNT_W(16)) u_l15 (
        .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .ctrl_out(ctrl_o[3]), .prevent_update_pc(ppc[3]),
        .prevent_update_reg_IF_ID(pif[3]), .flush_IF_ID(fl[3]), .stall_count(sc3));

    function automatic bit model_hit(input int k);
        bit dep;
        dep = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        return ex_memread && dep && !(zen[k] && ex_rd == '0);
    endfunction

    // Expected {prevent_pc, prevent_ifid, flush, ctrl_out} for instance k this cycle.
    function automatic logic [CW+2:0] model_out(input int k);
        bit p, f;
        f = branch_taken;
        p = !branch_taken && (m_rem[k] > 0 || model_hit(k));
        return {p, p, f, (p || f) ? {CW{1'b0}} : ctrl_in};
    endfunction

    task automatic model_tick();
        for (int k = 0; k < NI; k++) begin
            bit p;
            p = model_out(k)[CW+2];
            if (!rst_n) begin
                m_rem[k] = 0;
                m_cnt[k] = 0;
            end else begin
                if (m_rem[k] > 0)  m_rem[k] = branch_taken ? 0 : m_rem[k] - 1;
                else if (p)        m_rem[k] = lat[k] - 1;
                if (p && m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic next_cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ctrl_in = 11'h2A5; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        ex_memread = 1'b0; ex_rd = 5'd9; branch_taken = 1'b0;
    endtask

    task automatic set_hazard();
        ctrl_in = 11'h7FF; id_rs1 = 5'd5; id_rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd5; branch_taken = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_idle();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [CW+2:0] got;
        rst_n = 1'b0;
        set_idle();
        @(posedge clk); #1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            got = {ppc[k], pif[k], fl[k], ctrl_o[k]};
            n_checks++;
            if (got !== {3'b000, 11'h2A5}) begin
                n_errors++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=%h", k, got, {3'b000, 11'h2A5});
            end
            n_checks++;
            if (scnt[k] !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_count inst=%0d got=%0d exp=0", k, scnt[k]);
            end
        end
    endtask

    task automatic test_single_stall();
        apply_reset();
        set_hazard();
        #1;
        n_checks++;
        if ({ppc[0], pif[0], fl[0], ctrl_o[0]} !== {3'b110, 11'h000}) begin
            n_errors++;
            $display("FAIL single_stall_cycle got=%h exp=%h", {ppc[0], pif[0], fl[0], ctrl_o[0]}, {3'b110, 11'h000});
        end
        next_cycle();
        ex_memread = 1'b0;
        #1;
        n_checks++;
        if ({ppc[0], pif[0], fl[0], ctrl_o[0]} !== {3'b000, 11'h7FF}) begin
            n_errors++;
            $display("FAIL single_stall_release got=%h exp=%h", {ppc[0], pif[0], fl[0], ctrl_o[0]}, {3'b000, 11'h7FF});
        end
        n_checks++;
        if (scnt[0] !== 16'd1) begin
            n_errors++;
            $display("FAIL single_stall_count got=%0d exp=1", scnt[0]);
        end
    endtask

    task automatic test_multi_stall();
        logic [CW+2:0] exp;
        apply_reset();
        set_hazard();
        #1;
        for (int c = 0; c < 4; c++) begin
            exp = (c < 3) ? {3'b110, 11'h000} : {3'b000, 11'h7FF};
            n_checks++;
            if ({ppc[1], pif[1], fl[1], ctrl_o[1]} !== exp) begin
                n_errors++;
                $display("FAIL multi_stall cycle=%0d got=%h exp=%h", c, {ppc[1], pif[1], fl[1], ctrl_o[1]}, exp);
            end
            next_cycle();
            ex_memread = 1'b0;
            #1;
        end
        n_checks++;
        if (scnt[1] !== 16'd3) begin
            n_errors++;
            $display("FAIL multi_stall_count got=%0d exp=3", scnt[1]);
        end
        n_checks++;
        if (ppc[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL lat15_still_stalling got=%b exp=1", ppc[3]);
        end
    endtask

    task automatic test_no_false_stall();
        logic [CW+2:0] exp;
        apply_reset();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1; ctrl_in = 11'h155; branch_taken = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            exp = zen[k] ? {3'b000, 11'h155} : {3'b110, 11'h000};
            n_checks++;
            if ({ppc[k], pif[k], fl[k], ctrl_o[k]} !== exp) begin
                n_errors++;
                $display("FAIL x0_load inst=%0d got=%h exp=%h", k, {ppc[k], pif[k], fl[k], ctrl_o[k]}, exp);
            end
        end
        next_cycle();
        ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0; id_rs1 = 5'd3; ctrl_in = 11'h3C3;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ppc[k], pif[k], fl[k], ctrl_o[k]} !== {3'b000, 11'h3C3}) begin
                n_errors++;
                $display("FAIL unused_rs2 inst=%0d got=%h exp=%h", k, {ppc[k], pif[k], fl[k], ctrl_o[k]}, {3'b000, 11'h3C3});
            end
        end
        next_cycle();
    endtask

    task automatic test_branch_abort();
        apply_reset();
        set_hazard();
        #1;
        next_cycle();
        ex_memread = 1'b0;
        branch_taken = 1'b1;
        #1;
        n_checks++;
        if ({ppc[1], pif[1], fl[1], ctrl_o[1]} !== {3'b001, 11'h000}) begin
            n_errors++;
            $display("FAIL branch_abort got=%h exp=%h", {ppc[1], pif[1], fl[1], ctrl_o[1]}, {3'b001, 11'h000});
        end
        next_cycle();
        branch_taken = 1'b0;
        #1;
        n_checks++;
        if ({ppc[1], pif[1], fl[1], ctrl_o[1]} !== {3'b000, 11'h7FF}) begin
            n_errors++;
            $display("FAIL branch_abort_after got=%h exp=%h", {ppc[1], pif[1], fl[1], ctrl_o[1]}, {3'b000, 11'h7FF});
        end
        n_checks++;
        if (scnt[1] !== 16'd1) begin
            n_errors++;
            $display("FAIL branch_abort_count got=%0d exp=1", scnt[1]);
        end
    endtask

    task automatic test_hit_and_branch();
        apply_reset();
        set_hazard();
        branch_taken = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({ppc[k], pif[k], fl[k], ctrl_o[k]} !== {3'b001, 11'h000}) begin
                n_errors++;
                $display("FAIL hit_and_branch inst=%0d got=%h exp=%h", k, {ppc[k], pif[k], fl[k], ctrl_o[k]}, {3'b001, 11'h000});
            end
        end
        next_cycle();
        branch_taken = 1'b0;
        ex_memread = 1'b0;
        #1;
        n_checks++;
        if ({ppc[3], pif[3], fl[3], ctrl_o[3], scnt[3]} !== {3'b000, 11'h7FF, 16'd0}) begin
            n_errors++;
            $display("FAIL hit_and_branch_no_stall got=%h exp=%h", {ppc[3], pif[3], fl[3], ctrl_o[3], scnt[3]}, {3'b000, 11'h7FF, 16'd0});
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        set_hazard();
        #1;
        next_cycle();
        ex_memread = 1'b0;
        rst_n = 1'b0;
        #1;
        next_cycle();
        rst_n = 1'b1;
        #1;
        for (int k = 1; k < NI; k += 2) begin
            n_checks++;
            if ({ppc[k], pif[k], fl[k], ctrl_o[k], scnt[k]} !== {3'b000, 11'h7FF, 16'd0}) begin
                n_errors++;
                $display("FAIL reset_mid_stall inst=%0d got=%h exp=%h", k, {ppc[k], pif[k], fl[k], ctrl_o[k], scnt[k]}, {3'b000, 11'h7FF, 16'd0});
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_hazard();
        #1;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            n_checks++;
            if (scnt[2] !== 16'((i < 15) ? i : 15)) begin
                n_errors++;
                $display("FAIL saturation stalls=%0d got=%0d exp=%0d", i, scnt[2], (i < 15) ? i : 15);
            end
        end
        n_checks++;
        if (scnt[0] !== 16'd20) begin
            n_errors++;
            $display("FAIL wide_count got=%0d exp=20", scnt[0]);
        end
        set_idle();
        #1;
    endtask

    task automatic test_random();
        logic [CW+2:0] exp;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            ctrl_in      = CW'($urandom);
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            ex_rd        = RW'($urandom_range(0, 3));
            id_use_rs1   = ($urandom_range(0, 3) != 0);
            id_use_rs2   = ($urandom_range(0, 1) != 0);
            ex_memread   = ($urandom_range(0, 9) < 6);
            branch_taken = ($urandom_range(0, 9) == 0);
            #1;
            for (int k = 0; k < NI; k++) begin
                exp = model_out(k);
                n_checks++;
                if ({ppc[k], pif[k], fl[k], ctrl_o[k]} !== exp) begin
                    n_errors++;
                    $display("FAIL random_outputs iter=%0d inst=%0d got=%h exp=%h", n, k, {ppc[k], pif[k], fl[k], ctrl_o[k]}, exp);
                end
                n_checks++;
                if (scnt[k] !== 16'(m_cnt[k])) begin
                    n_errors++;
                    $display("FAIL random_count iter=%0d inst=%0d got=%0d exp=%0d", n, k, scnt[k], m_cnt[k]);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_stall();
        test_multi_stall();
        test_no_false_stall();
        test_branch_abort();
        test_hit_and_branch();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised successor to the ID-stage load-use hazard detector.
- Detects RAW hazards between the instruction in IF/ID and a load in ID/EX, then holds the PC and IF/ID for LOAD_LAT cycles while injecting bubbles into ID/EX. This covers multi-cycle data memories.
- Adds per-operand use qualification, optional x0 exclusion, taken-branch flush with priority over stalls, and a saturating stall-cycle performance counter.
- Sits between the control unit and the ID/EX pipeline register.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- CTRL_W, 11, width of the packed control bundle (alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump; LSB = jump).
- LOAD_LAT, 1, number of stall cycles per load-use hazard; legal range 1..15.
- ZERO_REG_EN, 1, when 1 a destination of register 0 never causes a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ctrl_in  in  CTRL_W  control bundle from the control unit.
- id_rs1  in  REG_ADDR_W  IF/ID rs1.
- id_rs2  in  REG_ADDR_W  IF/ID rs2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- ex_memread  in  1  ID/EX mem_read.
- ex_rd  in  REG_ADDR_W  ID/EX destination register.
- branch_taken  in  1  taken branch/jump resolved this cycle.
- ctrl_out  out  CTRL_W  bundle to ID/EX; all-zero when bubbling.
- prevent_update_pc  out  1  hold the PC.
- prevent_update_reg_IF_ID  out  1  hold IF/ID.
- flush_IF_ID  out  1  clear IF/ID to a NOP.
- stall_count  out  CNT_W  total stall cycles since reset.

Behaviour:
- Hazard term: hit = ex_memread & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & ~(ZERO_REG_EN & ex_rd==0).
- FSM states: IDLE, STALL. The remaining-cycle counter rem is 4 bits.
- IDLE with branch_taken=1:
  - flush_IF_ID=1, ctrl_out=0, prevent_* =0.
  - Next state IDLE; hit is ignored.
- IDLE with hit=1 and branch_taken=0:
  - prevent_*=1, ctrl_out=0 combinationally in the same cycle.
  - If LOAD_LAT>1: next state STALL, rem=LOAD_LAT-1. Otherwise stay IDLE.
- IDLE otherwise: ctrl_out=ctrl_in, all flags 0.
- STALL:
  - prevent_*=1, ctrl_out=0. hit is not re-evaluated, because ID/EX now holds a bubble.
  - rem decrements each cycle. When rem==1 at the clock edge, next state is IDLE.
  - The instruction is re-checked in IDLE on the following cycle; a second load-use cannot exist there, so the stall ends.
- Priority:
  - branch_taken during STALL aborts the stall: flush_IF_ID=1, prevent_*=0, ctrl_out=0, next state IDLE, rem=0.
  - Simultaneous hit and branch_taken resolves as flush.
- Total stall length per hazard is exactly LOAD_LAT cycles; prevent_* is high for exactly those cycles.
- stall_count:
  - Increments by 1 on every edge where prevent_update_pc=1.
  - Saturates at all-ones and never wraps.
- Reset: while rst_n=0 at an edge, state=IDLE, rem=0, stall_count=0.
  - Combinational outputs follow the IDLE equations.
  - Reset mid-STALL returns to IDLE on that edge; a pending stall is dropped.
- ctrl_out, prevent_*, flush_IF_ID are combinational from inputs and state, with zero latency. Only state, rem and stall_count are registered.
- The x0 check and use qualifiers eliminate false stalls, such as a load to x0 or an I-type instruction whose rs2 field matches.

Decomposition:
- Package hazard_pkg:
  - state enum {IDLE, STALL}.
  - CTRL field index constants (ALU_OP_MSB..JUMP_BIT).
  - Default REG_ADDR_W and CTRL_W.
- Sub-module hazard_match:
  - Combinational comparator producing hit from the rs/rd/use/memread inputs and ZERO_REG_EN.
  - Reusable by the forwarding unit.

Test Plan:
- LOAD_LAT=1, ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1, ctrl_in=11'h7FF -> prevent_*=1 and ctrl_out=0 for 1 cycle; next cycle ctrl_out=11'h7FF; stall_count=1.
- LOAD_LAT=3, same hazard, ex_memread dropping to 0 after the first cycle -> prevent_*=1 for exactly 3 consecutive cycles; states IDLE→STALL(rem 2,1)→IDLE; stall_count=3.
- ZERO_REG_EN=1, ex_rd=0=id_rs2, id_use_rs2=1; and separately id_rs2=5=ex_rd with id_use_rs2=0 -> no stall in either case, ctrl_out=ctrl_in.
- LOAD_LAT=3, branch_taken=1 in the 2nd stall cycle -> flush_IF_ID=1, prevent_*=0 that cycle, state IDLE next; stall_count=1.
- hit and branch_taken in the same cycle -> flush_IF_ID=1, prevent_*=0, no STALL entry; rst_n=0 during STALL -> IDLE, stall_count=0 on the next edge.
- CNT_W=4, 20 single-cycle stalls -> stall_count saturates at 4'hF.
